// File: rtl/grayscale_frame_ctrl_if.sv
// Pixel RAM / grayscale datapath bus for grayscale_frame_ctrl.
// master = controller side, slave = RAM + datapath side.
interface grayscale_frame_ctrl_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  din_valid;
  logic [7:0]            gray_in;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_data;

  modport master (
    output rd_en, rd_addr, din_valid, wr_en, wr_addr, wr_data,
    input  gray_in
  );

  modport slave (
    input  rd_en, rd_addr, din_valid, wr_en, wr_addr, wr_data,
    output gray_in
  );
endinterface

// File: rtl/grayscale_frame_ctrl.sv
// Frame sequencer: streams N pixel reads to the grayscale datapath and writes
// the results back in order, tracking RAM and datapath latency with valid shift registers.
module grayscale_frame_ctrl #(
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LAT     = 1,
  parameter int PIPE_LAT   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  grayscale_frame_ctrl_if.master mem,
  output logic                   busy,
  output logic                   done
);

  localparam int                    N         = IMG_W * IMG_H;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [RD_LAT-1:0]     dv_sr_q, dv_sr_d;
  logic [PIPE_LAT-1:0]   wv_sr_q, wv_sr_d;
  logic                  done_q, done_d;

  logic rd_en_s;
  logic din_valid_s;
  logic wr_en_s;

  assign rd_en_s     = (state_q == FETCH);
  assign din_valid_s = dv_sr_q[RD_LAT-1];
  assign wr_en_s     = wv_sr_q[PIPE_LAT-1];

  // Next-state, address counters and valid shift registers.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    done_d    = 1'b0;
    dv_sr_d   = RD_LAT'({dv_sr_q, rd_en_s});
    wv_sr_d   = PIPE_LAT'({wv_sr_q, din_valid_s});

    // Write counter saturates at the last pixel so it never wraps inside a frame.
    if (wr_en_s && (wr_addr_q != LAST_ADDR)) begin
      wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
    end else begin
      wr_addr_d = wr_addr_q;
    end

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = FETCH;
          rd_addr_d = '0;
          wr_addr_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d = IDLE;
          dv_sr_d = '0;
          wv_sr_d = '0;
        end else if (rd_addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
          dv_sr_d = '0;
          wv_sr_d = '0;
        end else if (done_q) begin
          state_d = IDLE;
        end else if (wr_en_s && (wr_addr_q == LAST_ADDR)) begin
          done_d = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        dv_sr_d = '0;
        wv_sr_d = '0;
      end
    endcase
  end

  // State and datapath-tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      dv_sr_q   <= '0;
      wv_sr_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      dv_sr_q   <= dv_sr_d;
      wv_sr_q   <= wv_sr_d;
      done_q    <= done_d;
    end
  end

  assign mem.rd_en     = rd_en_s;
  assign mem.rd_addr   = rd_addr_q;
  assign mem.din_valid = din_valid_s;
  assign mem.wr_en     = wr_en_s;
  assign mem.wr_addr   = wr_addr_q;
  assign mem.wr_data   = mem.gray_in;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

endmodule
